// File: rtl/block_downsampler.sv
// Streaming FACTORxFACTOR box-filter downsampler: sums each block of raster pixels in a
// row buffer and emits one re-thresholded bit per block with its bitmap write address.
module block_downsampler #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int FACTOR = 3,
    parameter int PIX_W  = 5,
    parameter int SUM_W  = PIX_W + $clog2(FACTOR*FACTOR+1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [PIX_W-1:0] pixel_data_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic [PIX_W-1:0] thresh_in,
    input  logic             invert_in,
    output logic             data_valid_out,
    output logic             pixel_out,
    output logic [SUM_W-1:0] sum_out,
    output logic [16:0]      addr_out,
    output logic [10:0]      hcount_out,
    output logic [9:0]       vcount_out,
    output logic             frame_done_out
);
    localparam int OUT_W = SRC_W / FACTOR;
    localparam int OUT_H = SRC_H / FACTOR;
    localparam int SUB_W = $clog2(FACTOR + 1);
    localparam int BX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [10:0]      H_LIM    = 11'(OUT_W * FACTOR);
    localparam logic [9:0]       V_LIM    = 10'(OUT_H * FACTOR);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(FACTOR - 1);
    localparam logic [BX_W-1:0]  BX_LAST  = BX_W'(OUT_W - 1);
    localparam logic [9:0]       BY_LAST  = 10'(OUT_H - 1);
    localparam logic [16:0]      ROW_STEP = 17'(OUT_W);
    localparam logic [SUM_W-1:0] AREA     = SUM_W'(FACTOR * FACTOR);

    logic [SUB_W-1:0] sub_x, sub_y, sx_n, sy_n;
    logic [BX_W-1:0]  blk_x, bx_n;
    logic [9:0]       blk_y, by_n;
    logic [16:0]      row_base, rb_n;
    logic             synced;
    logic             accept, first_px, last_px;
    logic [SUM_W-1:0] pix_ext, blk_sum, thresh_full;

    logic [SUM_W-1:0] row_buf [OUT_W];

    // Position of the incoming pixel, derived from the previous pixel's position.
    always_comb begin
        sx_n = sub_x;
        bx_n = blk_x;
        sy_n = sub_y;
        by_n = blk_y;
        rb_n = row_base;
        if (hcount_in == '0) begin
            sx_n = '0;
            bx_n = '0;
            if (vcount_in == '0) begin
                sy_n = '0;
                by_n = '0;
                rb_n = '0;
            end else if (sub_y == SUB_LAST) begin
                sy_n = '0;
                by_n = blk_y + 10'd1;
                rb_n = row_base + ROW_STEP;
            end else begin
                sy_n = sub_y + SUB_W'(1);
            end
        end else if (sub_x == SUB_LAST) begin
            sx_n = '0;
            bx_n = blk_x + BX_W'(1);
        end else begin
            sx_n = sub_x + SUB_W'(1);
        end
    end

    always_comb begin
        accept      = data_valid_in && (hcount_in < H_LIM) && (vcount_in < V_LIM) &&
                      (synced || (hcount_in == '0 && vcount_in == '0));
        first_px    = (sx_n == '0) && (sy_n == '0);
        last_px     = (sx_n == SUB_LAST) && (sy_n == SUB_LAST);
        pix_ext     = SUM_W'(pixel_data_in);
        blk_sum     = first_px ? pix_ext : row_buf[bx_n] + pix_ext;
        thresh_full = SUM_W'(thresh_in) * AREA;
    end

    // First pixel of a block overwrites, so the buffer never needs clearing.
    always_ff @(posedge clk_in) begin
        if (accept) row_buf[bx_n] <= blk_sum;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sub_x          <= '0;
            sub_y          <= '0;
            blk_x          <= '0;
            blk_y          <= '0;
            row_base       <= '0;
            synced         <= 1'b0;
            data_valid_out <= 1'b0;
            pixel_out      <= 1'b0;
            sum_out        <= '0;
            addr_out       <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            frame_done_out <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            if (accept) begin
                sub_x    <= sx_n;
                sub_y    <= sy_n;
                blk_x    <= bx_n;
                blk_y    <= by_n;
                row_base <= rb_n;
                synced   <= 1'b1;
                if (last_px) begin
                    data_valid_out <= 1'b1;
                    sum_out        <= blk_sum;
                    pixel_out      <= (blk_sum >= thresh_full) ^ invert_in;
                    addr_out       <= rb_n + 17'(bx_n);
                    hcount_out     <= 11'(bx_n);
                    vcount_out     <= by_n;
                    frame_done_out <= (bx_n == BX_LAST) && (by_n == BY_LAST);
                end
            end
        end
    end
endmodule

// File: tb/tb_block_downsampler.sv
// Drives two downsampler instances (F=3/PIX_W=5 and F=2/PIX_W=1) from one raster stream and
// checks every emitted block against block sums computed from a stored copy of the frame.
module tb_block_downsampler;
    localparam int SW = 31;
    localparam int SH = 19;

    logic        clk_in, rst_in, data_valid_in, invert_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [4:0]  pix_a, thresh_a;
    logic [0:0]  pix_b, thresh_b;

    logic        dva, pa, fda, dvb, pb, fdb;
    logic [8:0]  suma;
    logic [3:0]  sumb;
    logic [16:0] addra, addrb;
    logic [10:0] hca, hcb;
    logic [9:0]  vca, vcb;

    block_downsampler #(.SRC_W(SW), .SRC_H(SH), .FACTOR(3), .PIX_W(5)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .pixel_data_in(pix_a), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .thresh_in(thresh_a), .invert_in(invert_in),
        .data_valid_out(dva), .pixel_out(pa), .sum_out(suma), .addr_out(addra),
        .hcount_out(hca), .vcount_out(vca), .frame_done_out(fda));

    block_downsampler #(.SRC_W(SW), .SRC_H(SH), .FACTOR(2), .PIX_W(1)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .pixel_data_in(pix_b), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .thresh_in(thresh_b), .invert_in(invert_in),
        .data_valid_out(dvb), .pixel_out(pb), .sum_out(sumb), .addr_out(addrb),
        .hcount_out(hcb), .vcount_out(vcb), .frame_done_out(fdb));

    typedef struct {
        int cyc;
        int sum;
        int bit_v;
        int addr;
        int bx;
        int by;
        int done;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   img [2][SH][SW];
    int   synced [2];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   cval = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: once a block's bottom-right pixel arrives, sum the stored block.
    task automatic model_pix(input int id, input int h, input int v, input int p);
        int f, ow, oh, th, s, bx, by;
        exp_t e;
        f  = (id == 0) ? 3 : 2;
        ow = SW / f;
        oh = SH / f;
        th = (id == 0) ? int'(thresh_a) : int'(thresh_b);
        if (id == 1) p = (p >= 16) ? 1 : 0;
        if (h == 0 && v == 0) synced[id] = 1;
        if (synced[id] == 0 || h >= ow * f || v >= oh * f) return;
        img[id][v][h] = p;
        if ((h % f) != f - 1 || (v % f) != f - 1) return;
        bx = h / f;
        by = v / f;
        s  = 0;
        for (int dy = 0; dy < f; dy++)
            for (int dx = 0; dx < f; dx++)
                s += img[id][by * f + dy][bx * f + dx];
        e.cyc   = cyc;
        e.sum   = s;
        e.bit_v = ((s >= th * f * f) ? 1 : 0) ^ int'(invert_in);
        e.addr  = by * ow + bx;
        e.bx    = bx;
        e.by    = by;
        e.done  = (bx == ow - 1 && by == oh - 1) ? 1 : 0;
        if (id == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic check_out(input int id, input string nm, input logic dv, input logic pbit,
                             input logic [31:0] s, input logic [31:0] a, input logic [31:0] hc,
                             input logic [31:0] vc, input logic fd);
        exp_t e;
        int   n;
        if (dv === 1'b1) begin
            n = (id == 0) ? qa.size() : qb.size();
            chk({nm, ".pending"}, (n > 0) ? 1 : 0, 1);
            if (n > 0) begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                chk({nm, ".latency"}, cyc, e.cyc);
                chk({nm, ".sum"}, s, e.sum);
                chk({nm, ".bit"}, pbit, e.bit_v);
                chk({nm, ".addr"}, a, e.addr);
                chk({nm, ".hcount"}, hc, e.bx);
                chk({nm, ".vcount"}, vc, e.by);
                chk({nm, ".done"}, fd, e.done);
            end
        end else begin
            chk({nm, ".done_idle"}, fd, 0);
        end
    endtask

    always @(negedge clk_in) begin
        if (!rst_in) begin
            check_out(0, "a", dva, pa, 32'(suma), 32'(addra), 32'(hca), 32'(vca), fda);
            check_out(1, "b", dvb, pb, 32'(sumb), 32'(addrb), 32'(hcb), 32'(vcb), fdb);
        end
    end

    function automatic int gen_pix(input int pat, input int h, input int v);
        case (pat)
            0:       return cval;
            1:       return ((h + v) % 2 == 1) ? 31 : 0;
            2:       return (h >= 30 || v >= 18) ? 31 : 0;
            default: return int'($urandom_range(0, 31));
        endcase
    endfunction

    task automatic idle();
        data_valid_in = 1'b0;
        hcount_in     = 11'($urandom_range(0, 2047));
        vcount_in     = 10'($urandom_range(0, 1023));
        pix_a         = 5'($urandom_range(0, 31));
        pix_b         = 1'($urandom_range(0, 1));
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_pix(input int h, input int v, input int p);
        data_valid_in = 1'b1;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pix_a         = 5'(p);
        pix_b         = (p >= 16) ? 1'b1 : 1'b0;
        @(posedge clk_in);
        #1;
        model_pix(0, h, v, p);
        model_pix(1, h, v, p);
        data_valid_in = 1'b0;
    endtask

    task automatic feed(input int pat, input int r0, input int r1, input int max_gap);
        for (int v = r0; v <= r1; v++)
            for (int h = 0; h < SW; h++) begin
                drive_pix(h, v, gen_pix(pat, h, v));
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle();
            end
        idle();
        idle();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".a.dv"}, dva, 0);
        chk({tag, ".a.bit"}, pa, 0);
        chk({tag, ".a.sum"}, 32'(suma), 0);
        chk({tag, ".a.addr"}, 32'(addra), 0);
        chk({tag, ".a.hc"}, 32'(hca), 0);
        chk({tag, ".a.vc"}, 32'(vca), 0);
        chk({tag, ".a.done"}, fda, 0);
        chk({tag, ".b.dv"}, dvb, 0);
        chk({tag, ".b.bit"}, pb, 0);
        chk({tag, ".b.sum"}, 32'(sumb), 0);
        chk({tag, ".b.addr"}, 32'(addrb), 0);
        chk({tag, ".b.hc"}, 32'(hcb), 0);
        chk({tag, ".b.vc"}, 32'(vcb), 0);
        chk({tag, ".b.done"}, fdb, 0);
    endtask

    initial begin
        synced[0]     = 0;
        synced[1]     = 0;
        rst_in        = 1'b1;
        data_valid_in = 1'b0;
        hcount_in     = '0;
        vcount_in     = '0;
        pix_a         = '0;
        pix_b         = '0;
        thresh_a      = 5'd16;
        thresh_b      = 1'b1;
        invert_in     = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst_in = 1'b0;

        // Mid-stream reset, then the rest of the frame without a fresh origin pixel.
        cval = 31;
        feed(0, 0, 9, 0);
        rst_in    = 1'b1;
        synced[0] = 0;
        synced[1] = 0;
        #1;
        chk_zero("midrst");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        feed(0, 10, SH - 1, 0);

        feed(0, 0, SH - 1, 0);

        invert_in = 1'b1;
        feed(0, 0, SH - 1, 0);
        invert_in = 1'b0;

        // Sum exactly on the threshold product.
        cval = 16;
        feed(0, 0, SH - 1, 0);

        feed(1, 0, SH - 1, 0);
        thresh_a = 5'd14;
        thresh_b = 1'b0;
        feed(1, 0, SH - 1, 0);

        thresh_a = 5'd16;
        thresh_b = 1'b1;
        feed(2, 0, SH - 1, 0);

        for (int k = 0; k < 3; k++) begin
            thresh_a  = 5'($urandom_range(10, 22));
            thresh_b  = 1'($urandom_range(0, 1));
            invert_in = (k > 0) ? 1'b1 : 1'b0;
            feed(3, 0, SH - 1, 5);
        end
        invert_in = 1'b0;

        // Restart at the origin after row 4 drops the partial block row.
        feed(3, 0, 4, 2);
        feed(3, 0, SH - 1, 2);

        repeat (3) idle();
        chk("a.leftover", qa.size(), 0);
        chk("b.leftover", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
